// File: rtl/lms_sat_arbiter.sv
// Round-robin arbiter sharing one signed saturation stage among N_REQ LMS requesters.
// Registered valid/ready output tagged with requester id and clip flag, plus per-requester clip counters.
module lms_sat_arbiter #(
    parameter int N_REQ = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*IN_W-1:0]   req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_sat,
    input  logic [ID_W-1:0]         cnt_sel,
    output logic [CNT_W-1:0]        cnt_val,
    input  logic                    cnt_clr
);

    localparam logic signed [IN_W-1:0] SAT_HI_C = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_LO_C = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Returns {clip_flag, clipped_value}; all comparisons are signed.
    function automatic logic [OUT_W:0] sat_f(input logic signed [IN_W-1:0] x);
        logic [OUT_W:0] r;
        if (x > SAT_HI_C) begin
            r = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else if (x < SAT_LO_C) begin
            r = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            r = {1'b0, x[OUT_W-1:0]};
        end
        return r;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ID_W-1:0]   last_grant_r;
    logic [ID_W-1:0]   grant_id_s;
    logic [N_REQ-1:0]  grant_oh_s;
    logic              found_s;
    logic              accept_s;
    logic              grant_en_s;
    logic [IN_W-1:0]   sel_data_s;
    logic [OUT_W:0]    sat_res_s;
    logic [OUT_W-1:0]  out_data_r;
    logic [ID_W-1:0]   out_id_r;
    logic              out_sat_r;
    logic [CNT_W-1:0]  cnt_r [N_REQ];

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        logic [ID_W:0] idx_v;
        grant_id_s = '0;
        grant_oh_s = '0;
        found_s    = 1'b0;
        idx_v      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = {1'b0, last_grant_r} + (ID_W+1)'(k + 1);
            if (idx_v >= (ID_W+1)'(N_REQ)) begin
                idx_v = idx_v - (ID_W+1)'(N_REQ);
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && req_valid[idx_v[ID_W-1:0]]) begin
                found_s    = 1'b1;
                grant_id_s = idx_v[ID_W-1:0];
            end else begin
                found_s    = found_s;
            end
        end
        grant_oh_s[grant_id_s] = found_s;
    end

    assign out_valid  = (state_r == ST_FULL);
    assign accept_s   = ~out_valid | out_ready;
    assign grant_en_s = found_s & accept_s & ~rst;
    assign req_ready  = grant_oh_s & {N_REQ{grant_en_s}};
    assign sel_data_s = req_data[grant_id_s*IN_W +: IN_W];
    assign sat_res_s  = sat_f($signed(sel_data_s));

    // Output register occupancy: a grant always (re)fills, a drain without a grant empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (grant_en_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (grant_en_s) begin
                    state_nxt_s = ST_FULL;
                end else if (out_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result register and arbitration pointer; both move only on a real grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r   <= '0;
            out_id_r     <= '0;
            out_sat_r    <= 1'b0;
            last_grant_r <= ID_W'(N_REQ - 1);
        end else if (grant_en_s) begin
            out_data_r   <= sat_res_s[OUT_W-1:0];
            out_id_r     <= grant_id_s;
            out_sat_r    <= sat_res_s[OUT_W];
            last_grant_r <= grant_id_s;
        end
    end

    // Sticky clip counters; clear takes precedence over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_en_s && sat_res_s[OUT_W] && (grant_id_s == ID_W'(i)) &&
                    (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Same-cycle counter read; out-of-range selects read as zero.
    always_comb begin
        cnt_val = '0;
        if (32'(cnt_sel) < N_REQ) begin
            cnt_val = cnt_r[cnt_sel];
        end else begin
            cnt_val = '0;
        end
    end

    assign out_data = out_data_r;
    assign out_id   = out_id_r;
    assign out_sat  = out_sat_r;

endmodule

// File: tb/tb_lms_sat_arbiter.sv
// Bench for lms_sat_arbiter: behavioural model checked every cycle, plus directed vectors
// with hand-computed expectations.
module tb_lms_sat_arbiter;
    localparam int N    = 4;
    localparam int IN_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*IN_W-1:0] req_data;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [1:0]        out_id;
    logic              out_sat;
    logic [1:0]        cnt_sel;
    logic [15:0]       cnt_val;
    logic              cnt_clr;

    lms_sat_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_sat(out_sat),
        .cnt_sel(cnt_sel), .cnt_val(cnt_val), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    bit          chk_en = 1'b0;
    bit          m_valid = 1'b0;
    logic [15:0] m_data = 16'h0;
    int          m_id = 0;
    bit          m_sat = 1'b0;
    int          m_last = N - 1;
    int          m_cnt [N];
    int          grant_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic void sat_model(input logic [31:0] raw, output logic [15:0] d, output logic s);
        longint x;
        x = longint'($signed(raw));
        if (x > 32767) begin
            d = 16'h7FFF; s = 1'b1;
        end else if (x < -32768) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = raw[15:0]; s = 1'b0;
        end
    endfunction

    // Model: advance on each rising edge using the inputs present at that edge.
    always @(posedge clk) begin : model_p
        int w;
        logic [15:0] d;
        logic s;
        if (rst) begin
            m_valid = 1'b0; m_data = 16'h0; m_id = 0; m_sat = 1'b0; m_last = N - 1;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            w = winner(req_valid, m_last);
            if ((!m_valid || out_ready) && w >= 0) begin
                sat_model(req_data[w*IN_W +: IN_W], d, s);
                m_valid = 1'b1; m_data = d; m_id = w; m_sat = s; m_last = w;
                if (s && m_cnt[w] < 65535) m_cnt[w]++;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (cnt_clr) begin
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end
        end
    end

    // Compare DUT against the model mid-cycle and log every grant.
    always @(negedge clk) begin : cmp_p
        int w;
        logic [N-1:0] exp_rdy;
        if (chk_en) begin
            w = winner(req_valid, m_last);
            exp_rdy = '0;
            if (!rst && (!m_valid || out_ready) && w >= 0) exp_rdy[w] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_data",  32'(out_data),  32'(m_data));
            check("out_id",    32'(out_id),    m_id);
            check("out_sat",   32'(out_sat),   32'(m_sat));
            check("cnt_val",   32'(cnt_val),   m_cnt[cnt_sel]);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) grant_q.push_back(i);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_data[i*IN_W +: IN_W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    logic [15:0] bnd_data [4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    logic        bnd_sat  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
        cnt_clr = 1'b0; cnt_sel = 2'd0;
        cyc(2);
        chk_en = 1'b1;
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_cnt_val",   32'(cnt_val),   32'd0);

        // Single requester, no backpressure.
        cnt_sel = 2'd1;
        set_req(1, 32'h0000_1234); cyc(1);
        check("t1_data0", 32'(out_data), 32'h1234);
        check("t1_id0",   32'(out_id),   32'd1);
        check("t1_sat0",  32'(out_sat),  32'd0);
        set_req(1, 32'h0001_2345); cyc(1);
        check("t1_data1", 32'(out_data), 32'h7FFF);
        check("t1_sat1",  32'(out_sat),  32'd1);
        set_req(1, 32'hFFFE_0000); cyc(1);
        check("t1_data2", 32'(out_data), 32'h8000);
        check("t1_sat2",  32'(out_sat),  32'd1);
        check("t1_cnt",   32'(cnt_val),  32'd2);
        req_valid = '0; cyc(1);
        check("t1_drain", 32'(out_valid), 32'd0);

        // Round-robin fairness with boundary values on each requester.
        do_reset();
        set_req(0, 32'h0000_7FFF); set_req(1, 32'hFFFF_8000);
        set_req(2, 32'h0000_8000); set_req(3, 32'hFFFF_7FFF);
        grant_q.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("rr_id",   32'(out_id),   i % 4);
            check("rr_data", 32'(out_data), 32'(bnd_data[i % 4]));
            check("rr_sat",  32'(out_sat),  32'(bnd_sat[i % 4]));
        end
        req_valid = '0;
        check("rr_grants", grant_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_q.size()) check("rr_order", grant_q[i], i % 4);
        end
        cyc(1);

        // Backpressure: held result stays put, nothing granted, order resumes on release.
        do_reset();
        set_req(0, 32'h0000_0010); cyc(1);
        check("bp_first", 32'(out_id), 32'd0);
        req_valid[0] = 1'b0;
        set_req(1, 32'h0000_0020); set_req(2, 32'h0000_0030);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("bp_hold_data",  32'(out_data),  32'h10);
            check("bp_hold_id",    32'(out_id),    32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_ready_zero", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1; cyc(1);
        check("bp_rel_id",   32'(out_id),   32'd1);
        check("bp_rel_data", 32'(out_data), 32'h20);
        req_valid[1] = 1'b0; cyc(1);
        check("bp_next_id",  32'(out_id),   32'd2);
        req_valid = '0; cyc(1);

        // Counter saturation and clear-wins-over-increment.
        do_reset();
        cnt_sel = 2'd2;
        set_req(2, 32'h4000_0000);
        cyc(65536 + 3);
        check("cnt_stick", 32'(cnt_val), 32'hFFFF);
        cnt_clr = 1'b1; cyc(1);
        cnt_clr = 1'b0;
        check("cnt_clr", 32'(cnt_val), 32'd0);
        cyc(1);
        check("cnt_after_clr", 32'(cnt_val), 32'd1);

        // Reset while FULL with requests pending.
        out_ready = 1'b0;
        set_req(0, 32'h0005_0000); set_req(1, 32'h0000_0001); set_req(3, 32'h0000_0003);
        cyc(2);
        check("mid_full", 32'(out_valid), 32'd1);
        rst = 1'b1; cyc(1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cnt",   32'(cnt_val),   32'd0);
        rst = 1'b0; out_ready = 1'b1; cyc(1);
        check("mid_first_id", 32'(out_id), 32'd0);
        check("mid_first_sat", 32'(out_sat), 32'd1);
        req_valid = '0; cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
